// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding pipelined Wishbone B4 initiator fed by a
// valid/ready command stream; handles stall, ack, err, rty and a cyc timeout.
// Ports: clk_i/rst_n_i, cmd_* command in, rsp_* response out, wb_* master bus.
// Build option WB_CMD_MASTER_STATS_EN adds stat_ok_o/stat_err_o/stat_retry_o.
module wb_cmd_master #(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        rsp_timeout_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  input  logic        wb_stall_i
`ifdef WB_CMD_MASTER_STATS_EN
  ,
  output logic [15:0] stat_ok_o,
  output logic [15:0] stat_err_o,
  output logic [15:0] stat_retry_o
`endif
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_BACKOFF, S_RSP
  } state_e;

  state_e        state_q;
  logic          we_q;
  logic [31:0]   adr_q;
  logic [31:0]   dat_q;
  logic [3:0]    sel_q;
  logic [RW-1:0] retry_q;
  logic [TW-1:0] tmo_q;
  logic          cyc_q;
  logic          stb_q;
  logic          cmd_ready_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic          rsp_tmo_q;
  logic [31:0]   rsp_dat_q;

  logic busy, rty_ok, tmo_hit;
  logic ev_ok, ev_err, ev_tmo, ev_retry;

  // Outcome of the current bus cycle, err > rty > ack > timeout.
  always_comb begin
    busy     = (state_q == S_REQ) || (state_q == S_WAIT);
    rty_ok   = retry_q < RW'(MAX_RETRY);
    tmo_hit  = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));
    ev_retry = busy && !wb_err_i && wb_rty_i && rty_ok;
    ev_ok    = busy && !wb_err_i && !wb_rty_i && wb_ack_i;
    ev_tmo   = busy && !wb_err_i && !wb_rty_i && !wb_ack_i
               && tmo_hit;
    ev_err   = busy && (wb_err_i || (wb_rty_i && !rty_ok) || ev_tmo);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      retry_q     <= '0;
      tmo_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            we_q        <= cmd_we_i;
            adr_q       <= cmd_adr_i;
            dat_q       <= cmd_dat_i;
            sel_q       <= cmd_sel_i;
            retry_q     <= '0;
            tmo_q       <= '0;
            cyc_q       <= 1'b1;
            stb_q       <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= S_REQ;
          end
        end
        S_REQ, S_WAIT: begin
          tmo_q <= tmo_q + TW'(1);
          if (state_q == S_REQ && !wb_stall_i) begin
            stb_q   <= 1'b0;
            state_q <= S_WAIT;
          end
          if (ev_retry) begin
            retry_q <= retry_q + RW'(1);
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            state_q <= S_BACKOFF;
          end else if (ev_ok || ev_err) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ev_err;
            rsp_tmo_q   <= ev_tmo;
            rsp_dat_q   <= (ev_ok && !we_q) ? wb_dat_i : '0;
            state_q     <= S_RSP;
          end
        end
        S_BACKOFF: begin
          cyc_q   <= 1'b1;
          stb_q   <= 1'b1;
          tmo_q   <= '0;
          state_q <= S_REQ;
        end
        S_RSP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            rsp_dat_q   <= '0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_tmo_q;
  assign rsp_dat_o     = rsp_dat_q;
  assign wb_cyc_o      = cyc_q;
  assign wb_stb_o      = stb_q;
  assign wb_we_o       = we_q;
  assign wb_adr_o      = adr_q;
  assign wb_sel_o      = sel_q;
  assign wb_dat_o      = dat_q;

`ifdef WB_CMD_MASTER_STATS_EN
  logic [15:0] ok_q, err_q, rt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ok_q  <= '0;
      err_q <= '0;
      rt_q  <= '0;
    end else begin
      if (ev_ok && ok_q != 16'hFFFF)
        ok_q <= ok_q + 16'd1;
      if (ev_err && err_q != 16'hFFFF)
        err_q <= err_q + 16'd1;
      if (ev_retry && rt_q != 16'hFFFF)
        rt_q <= rt_q + 16'd1;
    end
  end

  assign stat_ok_o    = ok_q;
  assign stat_err_o   = err_q;
  assign stat_retry_o = rt_q;
`endif

endmodule
